memory_bus_bridge: RTL and testbench

MEMORY_BUS_BRIDGE -- requirements
Module: memory_bus_bridge

---
 rtl/memory_bus_bridge.sv | 138 +++++++++++++
 tb/tb_memory_bus_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_bridge.sv
// Bridges single Load/Store Unit accesses onto a simple req/ack memory bus.
// One access in flight at a time: IDLE -> ACCESS -> RESP -> IDLE, with timeout and fault reporting.
module memory_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_enable,
  input  logic        lsu_state,
  input  logic [31:0] lsu_address,
  input  logic [3:0]  lsu_frame_mask,
  inout  wire  [31:0] lsu_data,
  output logic        stall,
  output logic        access_fault,
  output logic [31:0] fault_address,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_error,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: during ACCESS bus_req stays high with stable addr/we/be/wdata until the
  // cycle bus_ack is seen high; that cycle completes the transfer. Outside ACCESS the
  // bus outputs are zero and bus_ack/bus_error are ignored.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        fault_d;
  logic        fault_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt_q;
  logic        req_bad;
  logic        timeout_hit;
  logic        in_access;
  logic        lsu_drive;
  logic [31:0] lane_mask;

  // A request with no enabled bytes, or with undefined mask/direction, never reaches the bus.
  assign req_bad     = (lsu_frame_mask == 4'b0000) ||
                       ((^{lsu_frame_mask, lsu_state}) === 1'bx);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1)) && !bus_ack;
  assign in_access   = (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (lsu_enable) begin
          if (req_bad) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // ack wins over a coincident timeout
        if (bus_ack) begin
          state_d = ST_RESP;
          fault_d = bus_error;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fault_q       <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      fault_address <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && lsu_enable) begin
        addr_q  <= lsu_address;
        we_q    <= lsu_state;
        be_q    <= {lsu_frame_mask[0], lsu_frame_mask[1], lsu_frame_mask[2], lsu_frame_mask[3]};
        wdata_q <= lsu_state ? lsu_data : '0;
      end
      if (!in_access) begin
        cnt_q <= '0;
      end else if (!bus_ack) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (in_access && bus_ack && !bus_error && !we_q) begin
        rdata_q <= bus_rdata;
      end
      if (state_d == ST_RESP) begin
        fault_q <= fault_d;
        // an invalid request faults straight from IDLE, before addr_q is loaded
        if (fault_d) fault_address <= (state_q == ST_IDLE) ? lsu_address : addr_q;
      end
    end
  end

  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  assign bus_req   = in_access;
  assign bus_we    = in_access && we_q;
  assign bus_addr  = in_access ? addr_q : '0;
  assign bus_be    = in_access ? be_q : '0;
  assign bus_wdata = (in_access && we_q) ? (wdata_q & lane_mask) : '0;

  assign stall        = ((state_q == ST_IDLE) && lsu_enable) || in_access;
  assign access_fault = (state_q == ST_RESP) && fault_q;
  assign dbg_state    = state_q;

  assign lsu_drive = lsu_enable && !lsu_state &&
                     ((state_q == ST_ACCESS) || (state_q == ST_RESP));
  assign lsu_data  = lsu_drive ? rdata_q : 32'bz;

endmodule

// File: tb/tb_memory_bus_bridge.sv
// Self-checking bench for memory_bus_bridge: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_memory_bus_bridge;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        lsu_enable;
  logic        lsu_state;
  logic [31:0] lsu_address;
  logic [3:0]  lsu_frame_mask;
  wire  [31:0] lsu_data;
  logic        stall;
  logic        access_fault;
  logic [31:0] fault_address;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_error;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  logic        tb_drive;
  logic [31:0] tb_data;
  assign lsu_data = tb_drive ? tb_data : 32'bz;

  int checks;
  int failures;
  logic [31:0] exp_fault_addr;
  logic [31:0] exp_q[$];

  memory_bus_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .lsu_enable(lsu_enable), .lsu_state(lsu_state), .lsu_address(lsu_address),
    .lsu_frame_mask(lsu_frame_mask), .lsu_data(lsu_data),
    .stall(stall), .access_fault(access_fault), .fault_address(fault_address),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_error(bus_error),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One LSU transaction. k = ACCESS cycle carrying bus_ack (1-based), k outside 1..TIMEOUT = no ack.
  // Leaves lsu_enable high after RESP so the caller may issue the next request back to back.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata, input int k, input logic err,
                         input logic [31:0] rdata, output int stall_n, output int req_n);
    logic [3:0]  be;
    logic [31:0] wexp;
    logic        valid;
    logic        fault;
    logic [31:0] got;
    int          a;
    be    = {mask[0], mask[1], mask[2], mask[3]};
    for (int i = 0; i < 4; i++) wexp[8*i +: 8] = (we && be[i]) ? wdata[8*i +: 8] : 8'h00;
    valid = (mask != 4'b0000);
    a     = (k >= 1 && k <= TIMEOUT) ? k : TIMEOUT;
    fault = !valid || (k < 1 || k > TIMEOUT) || err;
    if (valid && !we && !fault) exp_q.push_back(rdata);
    stall_n = 0;
    req_n   = 0;
    @(posedge clk); #1;
    lsu_enable = 1'b1; lsu_state = we; lsu_address = addr; lsu_frame_mask = mask;
    tb_drive = we; tb_data = wdata;
    bus_ack = 1'($urandom_range(0, 1)); bus_error = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_phase got stall=%b bus_req=%b exp stall=1 bus_req=0", stall, bus_req);
    end
    stall_n += int'(stall); req_n += int'(bus_req);
    if (valid) begin
      for (int c = 1; c <= a; c++) begin
        @(posedge clk); #1;
        lsu_address = {$urandom, 2'b00} ; lsu_frame_mask = 4'($urandom_range(0, 15));
        tb_data = $urandom;
        bus_ack   = (c == k);
        bus_error = (c == k) ? err : 1'($urandom_range(0, 1));
        bus_rdata = (c == k) ? rdata : $urandom;
        @(negedge clk);
        stall_n += int'(stall); req_n += int'(bus_req);
        checks++;
        if (stall !== 1'b1 || bus_req !== 1'b1 || bus_we !== we || bus_addr !== addr ||
            bus_be !== be || bus_wdata !== wexp) begin
          failures++;
          $display("FAIL access_cycle%0d got stall=%b req=%b we=%b addr=%h be=%b wdata=%h exp stall=1 req=1 we=%b addr=%h be=%b wdata=%h",
                   c, stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata, we, addr, be, wexp);
        end
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'($urandom_range(0, 1)); bus_error = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    @(negedge clk);
    stall_n += int'(stall); req_n += int'(bus_req);
    if (fault) exp_fault_addr = addr;
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'b0 || bus_wdata !== 32'b0) begin
      failures++;
      $display("FAIL resp_bus got stall=%b req=%b we=%b be=%b wdata=%h exp all zero",
               stall, bus_req, bus_we, bus_be, bus_wdata);
    end
    checks++;
    if (access_fault !== fault || fault_address !== exp_fault_addr) begin
      failures++;
      $display("FAIL resp_fault got fault=%b addr=%h exp fault=%b addr=%h",
               access_fault, fault_address, fault, exp_fault_addr);
    end
    if (valid && !we && !fault) begin
      got = lsu_data;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_rdata got=%h exp=<empty queue>", got);
      end else if (got !== exp_q[0]) begin
        failures++;
        $display("FAIL resp_rdata got=%h exp=%h", got, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    lsu_enable = 1'b0; tb_drive = 1'b0;
    bus_ack = 1'($urandom_range(0, 1)); bus_error = 1'($urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || access_fault !== 1'b0) begin
      failures++;
      $display("FAIL idle got stall=%b req=%b fault=%b exp 0 0 0", stall, bus_req, access_fault);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_ack = 1'b1; bus_error = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || access_fault !== 1'b0 || fault_address !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got stall=%b req=%b fault=%b faddr=%h exp 0 0 0 0",
               stall, bus_req, access_fault, fault_address);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus_ack = 1'b0; bus_error = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got stall=%b req=%b exp 0 0", stall, bus_req);
    end
    exp_fault_addr = 32'h0;
  endtask

  task automatic test_lw();
    int s, r;
    run_txn(1'b0, 32'h100, 4'b1111, 32'h0, 3, 1'b0, 32'hDEADBEEF, s, r);
    checks++;
    if (s != 4 || r != 3) begin
      failures++;
      $display("FAIL lw_latency got stall_cycles=%0d req_cycles=%0d exp 4 3", s, r);
    end
    idle_cycle();
  endtask

  task automatic test_sb();
    int s, r;
    run_txn(1'b1, 32'h204, 4'b0100, 32'h0000AB00, 2, 1'b0, 32'h0, s, r);
    checks++;
    if (s != 3 || r != 2 || fault_address !== 32'h0) begin
      failures++;
      $display("FAIL sb_summary got stall=%0d req=%0d faddr=%h exp 3 2 00000000", s, r, fault_address);
    end
    idle_cycle();
  endtask

  task automatic test_timeout();
    int s, r;
    run_txn(1'b0, 32'h300, 4'b1111, 32'h0, 0, 1'b0, 32'h0, s, r);
    checks++;
    if (r != TIMEOUT || s != TIMEOUT + 1) begin
      failures++;
      $display("FAIL timeout_len got req=%0d stall=%0d exp %0d %0d", r, s, TIMEOUT, TIMEOUT + 1);
    end
    idle_cycle();
    checks++;
    if (fault_address !== 32'h300) begin
      failures++;
      $display("FAIL timeout_faddr got=%h exp=00000300", fault_address);
    end
    // ack on the final allowed cycle completes normally
    run_txn(1'b0, 32'h310, 4'b1111, 32'h0, TIMEOUT, 1'b0, 32'h13572468, s, r);
    checks++;
    if (r != TIMEOUT) begin
      failures++;
      $display("FAIL ack_at_limit got req=%0d exp %0d", r, TIMEOUT);
    end
    idle_cycle();
  endtask

  task automatic test_bus_error();
    int s, r;
    run_txn(1'b1, 32'h440, 4'b1010, 32'h12345678, 2, 1'b1, 32'h0, s, r);
    run_txn(1'b0, 32'h444, 4'b0011, 32'h0, 1, 1'b0, 32'hA5A55A5A, s, r);
    checks++;
    if (s != 2 || fault_address !== 32'h440) begin
      failures++;
      $display("FAIL after_error got stall=%0d faddr=%h exp 2 00000440", s, fault_address);
    end
    idle_cycle();
  endtask

  task automatic test_invalid_mask();
    int s, r;
    run_txn(1'b0, 32'h500, 4'b0000, 32'h0, 1, 1'b0, 32'h0, s, r);
    checks++;
    if (s != 1 || r != 0) begin
      failures++;
      $display("FAIL invalid_mask got stall=%0d req=%0d exp 1 0", s, r);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int s, r;
    run_txn(1'b1, 32'h600, 4'b1000, 32'hCAFEF00D, 1, 1'b0, 32'h0, s, r);
    run_txn(1'b0, 32'h604, 4'b1111, 32'h0, 2, 1'b0, 32'h0BADF00D, s, r);
    run_txn(1'b1, 32'h608, 4'b0001, 32'h11223344, 1, 1'b0, 32'h0, s, r);
    checks++;
    if (s != 2 || r != 1) begin
      failures++;
      $display("FAIL back_to_back got stall=%0d req=%0d exp 2 1", s, r);
    end
    idle_cycle();
  endtask

  task automatic test_reset_in_access();
    @(posedge clk); #1;
    lsu_enable = 1'b1; lsu_state = 1'b0; lsu_address = 32'h700; lsu_frame_mask = 4'b1111;
    tb_drive = 1'b0; bus_ack = 1'b0; bus_error = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; lsu_enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_access_req got=%b exp=1", bus_req);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
    @(negedge clk);
    exp_fault_addr = 32'h0;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || access_fault !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop got req=%b stall=%b fault=%b exp 0 0 0", bus_req, stall, access_fault);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || access_fault !== 1'b0 || fault_address !== exp_fault_addr) begin
      failures++;
      $display("FAIL rst_no_resp got req=%b stall=%b fault=%b faddr=%h exp 0 0 0 %h",
               bus_req, stall, access_fault, fault_address, exp_fault_addr);
    end
  endtask

  task automatic test_random();
    int s, r, k;
    logic we, err;
    logic [3:0] mask;
    for (int n = 0; n < 30; n++) begin
      we   = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 4) == 0) k = $urandom_range(14, 20);
      else k = $urandom_range(0, 5);
      err  = ($urandom_range(0, 3) == 0);
      run_txn(we, {$urandom, 2'b00}, mask, $urandom, k, err, $urandom, s, r);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rdata_queue got leftover=%0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    checks = 0; failures = 0; exp_fault_addr = 32'h0;
    reset = 1'b1; lsu_enable = 1'b0; lsu_state = 1'b0; lsu_address = 32'h0;
    lsu_frame_mask = 4'b0; tb_drive = 1'b0; tb_data = 32'h0;
    bus_ack = 1'b0; bus_error = 1'b0; bus_rdata = 32'h0;
    test_reset();
    test_lw();
    test_sb();
    test_timeout();
    test_bus_error();
    test_invalid_mask();
    test_back_to_back();
    test_reset_in_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
